// File: rtl/heat_row_painter.sv
`timescale 1ns/1ps
// Purpose : collects one heat-map row of RGB332 cells and paints each cell as a SCALE x SCALE block into VGA pixel memory.
// Latency : the first pixel write appears 1 cycle after PAINT is entered, then one write per non-stalled cycle (SCALE*SCALE*GRID_W per row).
// Backpres: vga_busy holds the pending write and freezes the raster counters; comp_allow is withheld until the row is fully painted.
//
// Ports:
//   clk_50, reset          clock, async active-high reset
//   run                    level enable; gates issuing the next row request only
//   pix_data/pix_addr/pix_valid/row_done   colour stream from the producer
//   comp_allow             one-cycle request for the next row
//   vga_addr/vga_data/vga_we, vga_busy     pixel memory write port with stall
//   grid_row, frame_done   current grid row, end-of-frame pulse
// Optional: define HEAT_GRID_LINES_EN to draw the right/bottom pixel of every cell in black (cell outline).
module heat_row_painter #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 64,
    parameter int SCALE    = 4,
    parameter int X_OFF    = 192,
    parameter int Y_OFF    = 112,
    parameter int SCREEN_W = 640,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        pix_data,
    input  logic [7:0]        pix_addr,
    input  logic              pix_valid,
    input  logic              row_done,
    output logic              comp_allow,
    output logic [ADDR_W-1:0] vga_addr,
    output logic [7:0]        vga_data,
    output logic              vga_we,
    input  logic              vga_busy,
    output logic [7:0]        grid_row,
    output logic              frame_done
);

    localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int SX_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

    typedef enum logic [2:0] {IDLE, REQ, COLLECT, PAINT, NEXT} state_t;

    state_t            state, state_nxt;
    logic [7:0]        row_buf [GRID_W];
    logic [COL_W-1:0]  col;
    logic [SX_W-1:0]   sx, sy;
    logic              all_issued;   // final pixel of the row has been put on the bus
    logic              issue;        // launch the write for the current counters
    logic              finish;       // last write accepted, leave PAINT
    logic              last_cell;
    logic              in_range;
    logic [ADDR_W-1:0] pix_lin;
    logic [7:0]        colour;

    assign in_range  = ({1'b0, pix_addr} < 9'(GRID_W));
    assign last_cell = (sx == SX_W'(SCALE - 1)) && (sy == SX_W'(SCALE - 1)) &&
                       (col == COL_W'(GRID_W - 1));

    // Full-width linearised screen address of the current raster pixel.
    assign pix_lin = (ADDR_W'(Y_OFF) + ADDR_W'(grid_row) * ADDR_W'(SCALE) + ADDR_W'(sy))
                     * ADDR_W'(SCREEN_W)
                     + ADDR_W'(X_OFF) + ADDR_W'(col) * ADDR_W'(SCALE) + ADDR_W'(sx);

`ifdef HEAT_GRID_LINES_EN
    assign colour = ((sx == SX_W'(SCALE - 1)) || (sy == SX_W'(SCALE - 1))) ? 8'b000_000_00
                                                                            : row_buf[col];
`else
    assign colour = row_buf[col];
`endif

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE:    if (run) state_nxt = REQ;
            REQ:     state_nxt = COLLECT;
            COLLECT: if (row_done) state_nxt = PAINT;
            PAINT: begin
                if (!vga_busy) begin
                    if (all_issued) begin
                        finish    = 1'b1;
                        state_nxt = NEXT;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            NEXT:    state_nxt = run ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row buffer has no reset; contents are only meaningful once collected.
    always_ff @(posedge clk_50) begin
        if (state == COLLECT && pix_valid && in_range)
            row_buf[pix_addr[COL_W-1:0]] <= pix_data;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            comp_allow <= 1'b0;
            vga_we     <= 1'b0;
            vga_addr   <= '0;
            vga_data   <= '0;
            grid_row   <= '0;
            frame_done <= 1'b0;
            col        <= '0;
            sx         <= '0;
            sy         <= '0;
            all_issued <= 1'b0;
        end else begin
            comp_allow <= (state == REQ);
            frame_done <= 1'b0;

            if (state == NEXT) begin
                if (grid_row == 8'(GRID_H - 1)) begin
                    grid_row   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    grid_row <= grid_row + 8'd1;
                end
            end

            if (state != PAINT) begin
                col        <= '0;
                sx         <= '0;
                sy         <= '0;
                all_issued <= 1'b0;
            end

            if (issue) begin
                vga_we   <= 1'b1;
                vga_addr <= pix_lin;
                vga_data <= colour;
                if (last_cell) all_issued <= 1'b1;
                // Raster: sx innermost, then col, then sy.
                if (sx == SX_W'(SCALE - 1)) begin
                    sx <= '0;
                    if (col == COL_W'(GRID_W - 1)) begin
                        col <= '0;
                        sy  <= sy + SX_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end else begin
                    sx <= sx + SX_W'(1);
                end
            end else if (finish) begin
                vga_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_heat_row_painter.sv
`timescale 1ns/1ps
// Purpose : randomized self-checking bench for heat_row_painter against a raster-order pixel model.
// Latency : expects comp_allow 2 cycles after run rises and one pixel write per non-stalled PAINT cycle.
// Backpres: drives random and burst vga_busy stalls; a stalled write must hold and be counted once.
module tb_heat_row_painter;

    localparam int GRID_W   = 64;
    localparam int GRID_H   = 16;   // shortened frame keeps the run short
    localparam int SCALE    = 4;
    localparam int X_OFF    = 192;
    localparam int Y_OFF    = 112;
    localparam int SCREEN_W = 640;
    localparam int ADDR_W   = 19;
`ifdef HEAT_GRID_LINES_EN
    localparam int LAST_D   = 0;
`else
    localparam int LAST_D   = 63;
`endif

    logic              clk_50 = 1'b0;
    logic              reset, run, pix_valid, row_done, vga_busy;
    logic              comp_allow, vga_we, frame_done;
    logic [7:0]        pix_data, pix_addr, vga_data, grid_row;
    logic [ADDR_W-1:0] vga_addr;

    int vec_cnt = 0, err_cnt = 0;
    int addr_q[$];
    int data_q[$];
    int exp_buf[GRID_W];
    int comp_cnt = 0, comp_exp = 0, frame_cnt = 0, frame_exp = 0;
    int first_addr = -1, last_addr = -1, last_data = -1;
    int mon_a, mon_d, lat;
    bit held = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_data;

    always #10 clk_50 = ~clk_50;

    heat_row_painter #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .SCALE(SCALE), .X_OFF(X_OFF),
        .Y_OFF(Y_OFF), .SCREEN_W(SCREEN_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_50(clk_50), .reset(reset), .run(run),
        .pix_data(pix_data), .pix_addr(pix_addr), .pix_valid(pix_valid), .row_done(row_done),
        .comp_allow(comp_allow), .vga_addr(vga_addr), .vga_data(vga_data), .vga_we(vga_we),
        .vga_busy(vga_busy), .grid_row(grid_row), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Memory-side monitor: every accepted write must be the next pixel of the model raster.
    always @(negedge clk_50) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("busy_hold_addr", vga_addr, hold_addr);
                check("busy_hold_data", vga_data, hold_data);
                check("busy_hold_we", vga_we, 1);
            end
            if (comp_allow) comp_cnt++;
            if (frame_done) frame_cnt++;
            if (vga_we && !vga_busy) begin
                if (addr_q.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    mon_a = addr_q.pop_front();
                    mon_d = data_q.pop_front();
                    check("wr_addr", vga_addr, mon_a);
                    check("wr_data", vga_data, mon_d);
                    if (first_addr < 0) first_addr = int'(vga_addr);
                    last_addr = int'(vga_addr);
                    last_data = int'(vga_data);
                end
            end
            held      = vga_we && vga_busy;
            hold_addr = vga_addr;
            hold_data = vga_data;
        end
    end

    task automatic wait_req(input int max_cyc, output int l);
        l = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk_50);
            @(negedge clk_50);
            if (comp_allow) begin
                l = k;
                break;
            end
        end
    endtask

    // Collects one row from the producer side, then lets it paint under random stalls.
    // abort_at >= 0 asserts reset that many cycles into PAINT.
    task automatic paint_row(input int row, input int abort_at, input bit stop_run);
        for (int c = 0; c < GRID_W; c++)
            exp_buf[c] = (row == 0) ? c : int'($urandom_range(0, 255));
        for (int sy = 0; sy < SCALE; sy++)
            for (int c = 0; c < GRID_W; c++)
                for (int sx = 0; sx < SCALE; sx++) begin
                    addr_q.push_back((Y_OFF + row * SCALE + sy) * SCREEN_W + X_OFF + c * SCALE + sx);
`ifdef HEAT_GRID_LINES_EN
                    data_q.push_back((sx == SCALE - 1 || sy == SCALE - 1) ? 0 : exp_buf[c]);
`else
                    data_q.push_back(exp_buf[c]);
`endif
                end
        first_addr = -1;

        for (int c = 0; c < GRID_W; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            if (c == GRID_W - 1 || $urandom_range(0, 7) == 0) begin
                pix_valid = 1'b1;
                pix_addr  = (c == GRID_W - 1) ? ((row % 2) ? 8'd64 : 8'd70)
                                              : 8'($urandom_range(GRID_W, 255));
                pix_data  = 8'hE0;
                tick();
            end
            pix_valid = 1'b1;
            pix_addr  = 8'(c);
            pix_data  = 8'(exp_buf[c]);
            row_done  = (c == GRID_W - 1) && (row == 1 || $urandom_range(0, 1) == 1);
            tick();
        end
        check("we_collect", vga_we, 0);
        if (!row_done) begin
            pix_valid = 1'b0;
            row_done  = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        row_done  = 1'b0;
        if (stop_run) run = 1'b0;

        for (int n = 0; n < 3000 && addr_q.size() > 0; n++) begin
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_async_we", vga_we, 0);
                check("rst_grid_row", grid_row, 0);
                check("rst_addr", vga_addr, 0);
                addr_q.delete();
                data_q.delete();
                vga_busy  = 1'b0;
                pix_valid = 1'b0;
                row_done  = 1'b0;
                return;
            end
            vga_busy  = (n >= 200 && n < 205) || ($urandom_range(0, 15) == 0);
            pix_valid = ($urandom_range(0, 3) == 0);
            pix_addr  = 8'($urandom_range(0, GRID_W - 1));
            pix_data  = 8'($urandom);
            row_done  = ($urandom_range(0, 31) == 0);
            tick();
        end
        vga_busy  = 1'b0;
        pix_valid = 1'b0;
        row_done  = 1'b0;
        check("row_writes_left", addr_q.size(), 0);
    endtask

    task automatic end_of_row(input int row, input bit stop_run);
        int nxt;
        nxt = (row + 1) % GRID_H;
        if (stop_run) begin
            repeat (20) tick();
            check("idle_no_req", comp_cnt, comp_exp);
            check("idle_row", grid_row, nxt);
            check("idle_we", vga_we, 0);
            run = 1'b1;
        end
        wait_req(8, lat);
        check("req_seen", lat > 0, 1);
        comp_exp++;
        tick();
        check("req_count", comp_cnt, comp_exp);
        if (row == GRID_H - 1) frame_exp++;
        check("frame_done_cnt", frame_cnt, frame_exp);
        check("grid_row", grid_row, nxt);
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; pix_valid = 1'b0; row_done = 1'b0; vga_busy = 1'b0;
        pix_data = '0; pix_addr = '0;
        repeat (3) tick();
        check("rst_comp_allow", comp_allow, 0);
        check("rst_vga_we", vga_we, 0);
        check("rst_vga_addr", vga_addr, 0);
        check("rst_vga_data", vga_data, 0);
        check("rst_grid_row", grid_row, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        tick();
        run = 1'b1;
        wait_req(8, lat);
        check("first_req_lat", lat, 2);
        comp_exp = 1;
        tick();
        check("first_req_count", comp_cnt, comp_exp);

        for (int r = 0; r < GRID_H; r++) begin
            paint_row(r, -1, r == 2);
            if (r == 0) begin
                check("row0_first_addr", first_addr, 71872);
                check("row0_last_addr", last_addr, 74047);
                check("row0_last_data", last_data, LAST_D);
            end
            end_of_row(r, r == 2);
        end

        for (int r = 0; r < 10; r++) begin
            paint_row(r, -1, 1'b0);
            end_of_row(r, 1'b0);
        end

        paint_row(10, 150, 1'b0);
        tick();
        tick();
        check("rst_hold_we", vga_we, 0);
        reset = 1'b0;
        wait_req(8, lat);
        check("restart_req_lat", lat, 2);
        check("restart_row", grid_row, 0);
        comp_exp++;
        tick();
        check("restart_req_count", comp_cnt, comp_exp);
        paint_row(0, -1, 1'b0);
        check("restart_first_addr", first_addr, 71872);
        end_of_row(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
